// File: rtl/aes_round_key_store.sv
// AES-128 round key expansion and storage: one round key per cycle into an 11-entry register file,
// with a registered read port. Optional AES_KEY_ZEROIZE_EN adds a zeroize input that clears storage.
module aes_round_key_store #(
    parameter int unsigned NR_KEYS = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key,
    input  logic         key_en,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic [3:0]   round_no,
    output logic [127:0] round_key,
    output logic         key_ready,
    output logic         key_done
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Word 0 sits in [127:96]; the rotated word 3 is {b13,b14,b15,b12}.
    function automatic logic [127:0] expand_step(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
        w0 = w[127:96] ^ t;
        w1 = w[95:64]  ^ w0;
        w2 = w[63:32]  ^ w1;
        w3 = w[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t         state_q;
    state_t         state_d;
    logic [3:0]     cnt_q;
    logic [3:0]     cnt_d;
    logic           ready_d;
    logic           done_d;
    logic           mem_we;
    logic [3:0]     mem_waddr;
    logic [127:0]   mem_wdata;
    logic [127:0]   prev_key;
    logic [127:0]   rd_data;
    logic [127:0]   mem [NR_KEYS];

    always_comb begin
        prev_key = '0;
        rd_data  = '0;
        for (int unsigned i = 0; i < NR_KEYS; i++) begin
            if (cnt_q == 4'(i + 1)) prev_key = mem[i];
            if (round_no == 4'(i))  rd_data  = mem[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = key_ready;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = expand_step(prev_key, rcon(cnt_q));
`ifdef AES_KEY_ZEROIZE_EN
        if (zeroize) begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b0;
        end else
`endif
        if (key_en) begin
            state_d   = EXPAND;
            cnt_d     = 4'd1;
            ready_d   = 1'b0;
            mem_we    = 1'b1;
            mem_waddr = '0;
            mem_wdata = key;
        end else begin
            case (state_q)
                EXPAND: begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'(NR_KEYS - 1)) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_ready <= 1'b0;
            key_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_ready <= ready_d;
            key_done  <= done_d;
        end
    end

`ifdef AES_KEY_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (!reset || zeroize) begin
            for (int unsigned i = 0; i < NR_KEYS; i++) mem[i] <= '0;
            round_key <= '0;
        end else begin
            for (int unsigned i = 0; i < NR_KEYS; i++) begin
                if (mem_we && mem_waddr == 4'(i)) mem[i] <= mem_wdata;
            end
            round_key <= rd_data;
        end
    end
`else
    // Storage keeps its contents through reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NR_KEYS; i++) begin
                if (mem_we && mem_waddr == 4'(i)) mem[i] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) round_key <= '0;
        else        round_key <= rd_data;
    end
`endif

endmodule
